// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared state encoding and sizes for the round-robin mux arbiter
package mux_rr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
endpackage

// File: rtl/mux_rr_arbiter_pick4.sv
// rr_pick4: combinational round-robin pick, first requester after last in rotating order
// Ports: req[3:0] requests, last[1:0] previous owner, idx[1:0] chosen index, any = |req
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] off;
  logic [NREQ-1:0]  rot;
  assign base = last + 1'b1;
  // rot[k] is req[(last+1+k) mod 4], so the first set bit is the rotation winner
  assign rot  = NREQ'({req, req} >> base);
  assign off  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign idx  = base + off;
  assign any  = |req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the select lines of a shared 4:1 mux
// Ports: clk, rst_n (sync active-low), req[3:0] requests, gnt[3:0] one-hot registered grant,
//        addr0/addr1 registered mux select (owner index), busy = |gnt
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            addr0,
  output logic            addr1,
  output logic            busy
);
  localparam logic [CNT_W-1:0] LIM = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);
  state_t           state, n_state;
  logic [IDX_W-1:0] last, n_last, addr, n_addr;
  logic [IDX_W-1:0] n_idx, p_idx, g_idx;
  logic [CNT_W-1:0] hold_cnt, n_cnt;
  logic [NREQ-1:0]  n_gnt, mask;
  logic             n_any, p_any, own_req, at_lim, do_grant;
  // last doubles as the current owner while granted
  assign mask    = req & ~(NREQ'(1) << last);
  assign own_req = req[last];
  assign at_lim  = (MAX_HOLD != 0) && (hold_cnt == LIM);
  rr_pick4 u_pick (.req(req),  .last(last), .idx(n_idx), .any(n_any));
  rr_pick4 u_pre  (.req(mask), .last(last), .idx(p_idx), .any(p_any));
  // with the owner's req low, pick(req) equals pick(mask), so one masked pick serves both
  // the handoff and the preempt cases; only IDLE may re-grant the previous owner
  assign do_grant = (state == ST_IDLE) ? n_any : p_any && (!own_req || at_lim);
  assign g_idx    = (state == ST_IDLE) ? n_idx : p_idx;
  always_comb begin
    n_state = state;
    n_last  = last;
    n_addr  = addr;
    n_gnt   = gnt;
    n_cnt   = hold_cnt;
    if (do_grant) begin
      n_state = ST_GRANT;
      n_last  = g_idx;
      n_addr  = g_idx;
      n_gnt   = NREQ'(1) << g_idx;
      n_cnt   = '0;
    end else if (state == ST_GRANT && !own_req) begin
      n_state = ST_IDLE;
      n_gnt   = '0;
      n_cnt   = '0;
    end else if (state == ST_GRANT) begin
      n_cnt = (hold_cnt == LIM) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= 2'd3;
      addr     <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= n_state;
      last     <= n_last;
      addr     <= n_addr;
      gnt      <= n_gnt;
      hold_cnt <= n_cnt;
    end
  end
  assign addr0 = addr[0];
  assign addr1 = addr[1];
  assign busy  = |gnt;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed checks of two arbiter instances (MAX_HOLD=0 and MAX_HOLD=4)
module tb_mux_rr_arbiter;
  localparam logic [7:0] DIN [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic       clk = 0;
  logic       rst_n0, rst_n4;
  logic [3:0] req0, req4, gnt0, gnt4;
  logic       a00, a10, busy0, a04, a14, busy4;
  logic [7:0] mux0, mux4;
  int         n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mux_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n0), .req(req0), .gnt(gnt0), .addr0(a00), .addr1(a10), .busy(busy0));
  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n4), .req(req4), .gnt(gnt4), .addr0(a04), .addr1(a14), .busy(busy4));
  assign mux0 = DIN[{a10, a00}];
  assign mux4 = DIN[{a14, a04}];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp0(input string tag, input logic [3:0] g, input logic [1:0] a);
    chk({tag, "_gnt"}, 32'(gnt0), 32'(g));
    chk({tag, "_addr"}, 32'({a10, a00}), 32'(a));
    chk({tag, "_busy"}, 32'(busy0), 32'(g != 0));
    chk({tag, "_mux"}, 32'(mux0), 32'(DIN[a]));
  endtask
  task automatic exp4(input string tag, input logic [3:0] g, input logic [1:0] a);
    chk({tag, "_gnt"}, 32'(gnt4), 32'(g));
    chk({tag, "_addr"}, 32'({a14, a04}), 32'(a));
    chk({tag, "_busy"}, 32'(busy4), 32'(g != 0));
  endtask
  initial begin
    rst_n0 = 0; rst_n4 = 0; req0 = 4'b1111; req4 = 4'b0000;
    tick(); tick();
    exp0("rst", 4'b0000, 2'd0);
    exp4("rst4", 4'b0000, 2'd0);
    rst_n0 = 1; rst_n4 = 1;
    tick();
    exp0("rel", 4'b0001, 2'd0);
    exp4("idle4", 4'b0000, 2'd0);
    req0 = 4'b0000;
    tick();
    exp0("drop0", 4'b0000, 2'd0);
    req0 = 4'b0100;
    tick();
    exp0("single", 4'b0100, 2'd2);
    req0 = 4'b0000;
    tick();
    exp0("single_drop", 4'b0000, 2'd2);
    rst_n0 = 0;
    tick();
    rst_n0 = 1; req0 = 4'b1111;
    tick();
    exp0("rot0", 4'b0001, 2'd0);
    req0 = 4'b1110;
    tick();
    exp0("rot1", 4'b0010, 2'd1);
    req0 = 4'b1100;
    tick();
    exp0("rot2", 4'b0100, 2'd2);
    req0 = 4'b1000;
    tick();
    exp0("rot3", 4'b1000, 2'd3);
    req0 = 4'b0001;
    tick();
    exp0("rot4", 4'b0001, 2'd0);
    req0 = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("nopre0", 32'(gnt0), 32'h1);
    end
    req0 = 4'b0000;
    tick();
    exp0("nopre0_end", 4'b0000, 2'd0);
    req4 = 4'b0010;
    tick();
    exp4("pre_c1", 4'b0010, 2'd1);
    req4 = 4'b1010;
    for (int i = 2; i <= 4; i++) begin
      tick();
      exp4("pre_hold", 4'b0010, 2'd1);
    end
    tick();
    exp4("pre_switch", 4'b1000, 2'd3);
    tick();
    exp4("pre_own3", 4'b1000, 2'd3);
    req4 = 4'b0010;
    tick();
    exp4("pre_back1", 4'b0010, 2'd1);
    req4 = 4'b0100;
    tick();
    exp4("alone", 4'b0100, 2'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("alone_hold", 32'(gnt4), 32'h4);
    end
    chk("hold_sat", 32'(u4.hold_cnt), 32'd3);
    req4 = 4'b1000;
    tick();
    exp4("mid_gnt", 4'b1000, 2'd3);
    rst_n4 = 0; req4 = 4'b1001;
    tick();
    exp4("mid_rst", 4'b0000, 2'd0);
    rst_n4 = 1;
    tick();
    exp4("mid_rel", 4'b0001, 2'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
